// File: rtl/dp_sink_aux_responder.sv
// DisplayPort sink-side AUX responder: decodes native AUX requests, serves them
// from a DPCD byte array, replies ACK/NACK/DEFER, drives HPD with IRQ pulses,
// and mirrors the link-training registers onto the PHY instruction outputs.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | waiting for a rising aux_in_start_stop; B0 captured on entry
//   S_HDR    | collecting header bytes B1..B3
//   S_DATA   | collecting write data into the burst buffer
//   S_CHECK  | classify request: discard / DEFER / NACK / ACK
//   S_COMMIT | write buffered bytes into DPCD, one per cycle
//   S_WAIT   | reply turnaround delay
//   S_REPLY  | drive reply header and read data
//   S_DRAIN  | oversize request, wait for framing to end, no reply
module dp_sink_aux_responder #(
    parameter int         AUX_DATA_WIDTH  = 8,
    parameter int         MAX_LANES       = 4,
    parameter logic [7:0] MAX_LINK_RATE   = 8'h1E,
    parameter int         DPCD_ADDR_WIDTH = 9,
    parameter int         MAX_BURST       = 16,
    parameter int         REPLY_DELAY     = 4,
    parameter int         HPD_IRQ_CYCLES  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AUX_DATA_WIDTH-1:0] aux_in,
    input  logic                      aux_in_start_stop,
    output logic [AUX_DATA_WIDTH-1:0] aux_out,
    output logic                      aux_out_start_stop,
    input  logic                      defer_req,
    input  logic                      hpd_connect,
    input  logic                      hpd_irq_req,
    output logic                      HPD_Signal,
    output logic [1:0]                CR_PHY_Instruct,
    output logic [1:0]                EQ_PHY_Instruct,
    output logic [AUX_DATA_WIDTH-1:0] CR_ADJ_BW,
    output logic [AUX_DATA_WIDTH-1:0] EQ_ADJ_BW,
    output logic [1:0]                CR_ADJ_LC,
    output logic [1:0]                EQ_ADJ_LC
);

    localparam int DPCD_SIZE = 1 << DPCD_ADDR_WIDTH;
    localparam int BUF_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int DLY_W     = (REPLY_DELAY > 1) ? $clog2(REPLY_DELAY) : 1;
    localparam int HPD_W     = $clog2(HPD_IRQ_CYCLES + 1);

    localparam int ADDR_LINK_BW  = 'h100;
    localparam int ADDR_LANE_CNT = 'h101;
    localparam int ADDR_TRAIN    = 'h102;

    localparam logic [3:0] CMD_WRITE = 4'b1000;
    localparam logic [3:0] CMD_READ  = 4'b1001;
    localparam logic [1:0] RC_ACK    = 2'd0;
    localparam logic [1:0] RC_NACK   = 2'd1;
    localparam logic [1:0] RC_DEFER  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_CHECK, S_COMMIT, S_WAIT, S_REPLY, S_DRAIN
    } state_t;

    // With no turnaround delay the reply starts straight after CHECK/COMMIT.
    localparam state_t S_AFTER = (REPLY_DELAY == 0) ? S_REPLY : S_WAIT;

    state_t state, state_nxt;

    logic                       sss_q;
    logic [3:0]                 cmd;
    logic [19:0]                addr;
    logic [7:0]                 len_m1;
    logic [2:0]                 hdr_cnt;
    logic [8:0]                 data_cnt;
    logic                       defer_q;
    logic [1:0]                 reply_code;
    logic [8:0]                 idx;
    logic [DLY_W-1:0]           dly_cnt;
    logic [HPD_W-1:0]           irq_cnt;
    logic [AUX_DATA_WIDTH-1:0]  wbuf [MAX_BURST];
    logic [AUX_DATA_WIDTH-1:0]  dpcd [DPCD_SIZE];

    logic                       start;
    logic [8:0]                 len;
    logic [20:0]                end_addr;
    logic [20:0]                commit_full;
    logic                       commit_ro;
    logic [DPCD_ADDR_WIDTH-1:0] commit_addr;
    logic [DPCD_ADDR_WIDTH-1:0] read_addr;
    logic                       is_write;
    logic                       is_read;
    logic                       malformed;
    logic                       reject;
    logic [8:0]                 reply_last;
    logic [1:0]                 tps;
    logic [1:0]                 lane_code;

    // Only a fresh rising edge of framing starts a request, so a frame that
    // began while busy is ignored in its entirety.
    assign start       = aux_in_start_stop && !sss_q;
    assign len         = {1'b0, len_m1} + 9'd1;
    assign end_addr    = {1'b0, addr} + {12'd0, len};
    assign commit_full = {1'b0, addr} + {12'd0, idx};
    assign commit_ro   = commit_full < 21'h100;
    assign commit_addr = commit_full[DPCD_ADDR_WIDTH-1:0];
    assign read_addr   = addr[DPCD_ADDR_WIDTH-1:0] + DPCD_ADDR_WIDTH'(idx - 9'd1);
    assign is_write    = (cmd == CMD_WRITE);
    assign is_read     = (cmd == CMD_READ);
    assign malformed   = (hdr_cnt != 3'd4) || (is_write && (data_cnt != len));
    assign reject      = !(is_write || is_read) || (len > 9'(MAX_BURST))
                         || (end_addr > 21'(DPCD_SIZE));
    assign reply_last  = (reply_code == RC_ACK && is_read) ? len : 9'd0;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_HDR;
            S_HDR: begin
                if (!aux_in_start_stop)  state_nxt = S_CHECK;
                else if (hdr_cnt == 3'd3) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (!aux_in_start_stop)               state_nxt = S_CHECK;
                else if (data_cnt == 9'(MAX_BURST))   state_nxt = S_DRAIN;
            end
            S_CHECK: begin
                if (malformed)     state_nxt = S_IDLE;
                else if (defer_q)  state_nxt = S_AFTER;
                else if (reject)   state_nxt = S_AFTER;
                else if (is_write) state_nxt = S_COMMIT;
                else               state_nxt = S_AFTER;
            end
            S_COMMIT: if (idx == len - 9'd1) state_nxt = S_AFTER;
            S_WAIT:   if (dly_cnt == '0) state_nxt = S_REPLY;
            S_REPLY:  if (idx == reply_last) state_nxt = S_IDLE;
            S_DRAIN:  if (!aux_in_start_stop) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Request capture, reply classification and step counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sss_q      <= 1'b0;
            cmd        <= '0;
            addr       <= '0;
            len_m1     <= '0;
            hdr_cnt    <= '0;
            data_cnt   <= '0;
            defer_q    <= 1'b0;
            reply_code <= RC_ACK;
            idx        <= '0;
            dly_cnt    <= '0;
        end else begin
            sss_q <= aux_in_start_stop;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cmd      <= aux_in[7:4];
                        addr     <= {aux_in[3:0], 16'h0000};
                        hdr_cnt  <= 3'd1;
                        data_cnt <= '0;
                        defer_q  <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (aux_in_start_stop) begin
                        case (hdr_cnt)
                            3'd1:    addr[15:8] <= aux_in[7:0];
                            3'd2:    addr[7:0]  <= aux_in[7:0];
                            3'd3:    len_m1     <= aux_in[7:0];
                            default: ;
                        endcase
                        hdr_cnt <= hdr_cnt + 3'd1;
                    end else begin
                        defer_q <= defer_req;
                    end
                end
                S_DATA: begin
                    if (aux_in_start_stop) begin
                        if (data_cnt < 9'(MAX_BURST)) data_cnt <= data_cnt + 9'd1;
                    end else begin
                        defer_q <= defer_req;
                    end
                end
                S_CHECK: begin
                    if (defer_q)     reply_code <= RC_DEFER;
                    else if (reject) reply_code <= RC_NACK;
                    else             reply_code <= RC_ACK;
                end
                default: ;
            endcase

            if (state_nxt != state)
                idx <= '0;
            else if (state == S_COMMIT || state == S_REPLY)
                idx <= idx + 9'd1;

            if (state_nxt == S_WAIT && state != S_WAIT)
                dly_cnt <= DLY_W'(REPLY_DELAY - 1);
            else if (state == S_WAIT)
                dly_cnt <= dly_cnt - 1'b1;
        end
    end

    // Write data burst buffer; contents are don't-care until filled.
    always_ff @(posedge clk) begin
        if (state == S_DATA && aux_in_start_stop && data_cnt < 9'(MAX_BURST))
            wbuf[data_cnt[BUF_W-1:0]] <= aux_in;
    end

    function automatic logic [AUX_DATA_WIDTH-1:0] dpcd_init(input int a);
        case (a)
            0:       return AUX_DATA_WIDTH'(8'h14);
            1:       return AUX_DATA_WIDTH'(MAX_LINK_RATE);
            2:       return AUX_DATA_WIDTH'(MAX_LANES);
            default: return '0;
        endcase
    endfunction

    // DPCD storage; the capability page below 0x100 ignores source writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DPCD_SIZE; i++) dpcd[i] <= dpcd_init(i);
        end else if (state == S_COMMIT && !commit_ro) begin
            dpcd[commit_addr] <= wbuf[idx[BUF_W-1:0]];
        end
    end

    // Reply byte driver: header then read data, idle low otherwise.
    always_comb begin
        aux_out            = '0;
        aux_out_start_stop = 1'b0;
        if (state == S_REPLY) begin
            aux_out_start_stop = 1'b1;
            if (idx == 9'd0) aux_out = AUX_DATA_WIDTH'({2'b00, reply_code, 4'b0000});
            else             aux_out = dpcd[read_addr];
        end
    end

    // Training mirror: CR outputs live during pattern 1, EQ outputs during 2/3.
    always_comb begin
        tps = dpcd[ADDR_TRAIN][1:0];
        case (dpcd[ADDR_LANE_CNT][4:0])
            5'd1:    lane_code = 2'd0;
            5'd2:    lane_code = 2'd1;
            5'd4:    lane_code = 2'd2;
            default: lane_code = 2'd0;
        endcase
        CR_PHY_Instruct = '0;
        CR_ADJ_BW       = '0;
        CR_ADJ_LC       = '0;
        EQ_PHY_Instruct = '0;
        EQ_ADJ_BW       = '0;
        EQ_ADJ_LC       = '0;
        if (tps == 2'd1) begin
            CR_PHY_Instruct = tps;
            CR_ADJ_BW       = dpcd[ADDR_LINK_BW];
            CR_ADJ_LC       = lane_code;
        end else if (tps[1]) begin
            EQ_PHY_Instruct = tps;
            EQ_ADJ_BW       = dpcd[ADDR_LINK_BW];
            EQ_ADJ_LC       = lane_code;
        end
    end

    // HPD level with IRQ low pulse; the counter doubles as the pulse-active flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            HPD_Signal <= 1'b0;
            irq_cnt    <= '0;
        end else if (!hpd_connect) begin
            HPD_Signal <= 1'b0;
            irq_cnt    <= '0;
        end else if (irq_cnt != '0) begin
            irq_cnt    <= irq_cnt - 1'b1;
            HPD_Signal <= (irq_cnt == HPD_W'(1));
        end else if (hpd_irq_req && HPD_Signal) begin
            irq_cnt    <= HPD_W'(HPD_IRQ_CYCLES);
            HPD_Signal <= 1'b0;
        end else begin
            HPD_Signal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dp_sink_aux_responder.sv
// Directed bench for dp_sink_aux_responder: table of AUX transactions with
// hand-computed replies and latencies, plus training, HPD and reset sequences.
module tb_dp_sink_aux_responder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] aux_in;
    logic       aux_in_start_stop;
    logic [7:0] aux_out;
    logic       aux_out_start_stop;
    logic       defer_req;
    logic       hpd_connect;
    logic       hpd_irq_req;
    logic       HPD_Signal;
    logic [1:0] CR_PHY_Instruct, EQ_PHY_Instruct;
    logic [7:0] CR_ADJ_BW, EQ_ADJ_BW;
    logic [1:0] CR_ADJ_LC, EQ_ADJ_LC;

    dp_sink_aux_responder dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .aux_in             (aux_in),
        .aux_in_start_stop  (aux_in_start_stop),
        .aux_out            (aux_out),
        .aux_out_start_stop (aux_out_start_stop),
        .defer_req          (defer_req),
        .hpd_connect        (hpd_connect),
        .hpd_irq_req        (hpd_irq_req),
        .HPD_Signal         (HPD_Signal),
        .CR_PHY_Instruct    (CR_PHY_Instruct),
        .EQ_PHY_Instruct    (EQ_PHY_Instruct),
        .CR_ADJ_BW          (CR_ADJ_BW),
        .EQ_ADJ_BW          (EQ_ADJ_BW),
        .CR_ADJ_LC          (CR_ADJ_LC),
        .EQ_ADJ_LC          (EQ_ADJ_LC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:7][7:0]  req;
        int               nreq;
        bit               defer;
        logic [0:16][7:0] exp;
        int               nexp;
        int               lat;
    } vec_t;

    vec_t       vecs [32];
    int         nv = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] rsp [32];
    int         rsp_n, rsp_lat;
    bit         gap, idle_bad;
    logic [1:0] eq_hist [0:64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input int nreq, input logic [63:0] r, input bit d,
                       input int ne, input logic [135:0] e, input int lat);
        vecs[nv].req   = r;
        vecs[nv].nreq  = nreq;
        vecs[nv].defer = d;
        vecs[nv].exp   = e;
        vecs[nv].nexp  = ne;
        vecs[nv].lat   = lat;
        nv++;
    endtask

    // Send one request, then watch 64 cycles after the falling edge.
    task automatic run(input vec_t v);
        for (int i = 0; i < v.nreq; i++) begin
            aux_in_start_stop = 1'b1;
            aux_in            = v.req[i];
            @(posedge clk); #1;
        end
        aux_in_start_stop = 1'b0;
        aux_in            = 8'h00;
        defer_req         = v.defer;
        @(posedge clk); #1;
        defer_req = 1'b0;
        rsp_n = 0; rsp_lat = -1; gap = 0; idle_bad = 0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            eq_hist[k] = EQ_PHY_Instruct;
            if (aux_out_start_stop) begin
                if (rsp_n > 0 && gap) idle_bad = 1;
                if (rsp_n == 0) rsp_lat = k;
                if (rsp_n < 32) rsp[rsp_n] = aux_out;
                rsp_n++;
            end else begin
                if (rsp_n > 0) gap = 1;
                if (aux_out !== 8'h00) idle_bad = 1;
            end
        end
    endtask

    task automatic run_and_check(input int i);
        run(vecs[i]);
        chk($sformatf("v%0d_nbytes", i), rsp_n, vecs[i].nexp);
        for (int b = 0; b < vecs[i].nexp && b < rsp_n && b < 32; b++)
            chk($sformatf("v%0d_byte%0d", i, b), rsp[b], vecs[i].exp[b]);
        if (vecs[i].nexp > 0)
            chk($sformatf("v%0d_latency", i), rsp_lat, vecs[i].lat);
        chk($sformatf("v%0d_idle_or_gap", i), idle_bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ntab, low_n, first_low, last_low;
        rst_n = 1'b0; aux_in = 8'h00; aux_in_start_stop = 1'b0;
        defer_req = 1'b0; hpd_connect = 1'b0; hpd_irq_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_aux_out", aux_out, 0);
        chk("rst_aux_sss", aux_out_start_stop, 0);
        chk("rst_hpd", HPD_Signal, 0);
        chk("rst_cr_phy", CR_PHY_Instruct, 0);
        chk("rst_eq_phy", EQ_PHY_Instruct, 0);
        chk("rst_cr_bw", CR_ADJ_BW, 0);
        chk("rst_cr_lc", CR_ADJ_LC, 0);

        add(4, 64'h90000002_00000000, 0, 4, {8'h00, 8'h14, 8'h1E, 8'h04, 104'h0}, 1 + D);
        add(7, 64'h80010002_0A040100, 0, 1, {8'h00, 128'h0}, 1 + 3 + D);
        add(4, 64'h90010002_00000000, 0, 4, {8'h00, 8'h0A, 8'h04, 8'h01, 104'h0}, 1 + D);
        add(4, 64'h90000010_00000000, 0, 1, {8'h10, 128'h0}, 1 + D);
        add(4, 64'h9001FF01_00000000, 0, 1, {8'h10, 128'h0}, 1 + D);
        add(4, 64'h9001FF00_00000000, 0, 2, {8'h00, 8'h00, 120'h0}, 1 + D);
        add(5, 64'h80000100_55000000, 0, 1, {8'h00, 128'h0}, 1 + 1 + D);
        add(4, 64'h90000100_00000000, 0, 2, {8'h00, 8'h1E, 120'h0}, 1 + D);
        add(4, 64'h10000000_00000000, 0, 1, {8'h10, 128'h0}, 1 + D);
        add(5, 64'h80010300_77000000, 1, 1, {8'h20, 128'h0}, 1 + D);
        add(4, 64'h90010300_00000000, 0, 2, {8'h00, 8'h00, 120'h0}, 1 + D);
        add(3, 64'h90000000_00000000, 0, 0, 136'h0, 0);
        add(4, 64'h90000200_00000000, 0, 2, {8'h00, 8'h04, 120'h0}, 1 + D);
        add(5, 64'h80011001_AA000000, 0, 0, 136'h0, 0);
        add(4, 64'h90011000_00000000, 0, 2, {8'h00, 8'h00, 120'h0}, 1 + D);
        add(4, 64'h9000000F_00000000, 0, 17, {8'h00, 8'h14, 8'h1E, 8'h04, 104'h0}, 1 + D);
        add(6, 64'h8001FF01_11220000, 0, 1, {8'h10, 128'h0}, 1 + D);
        add(5, 64'h8001FF00_5A000000, 0, 1, {8'h00, 128'h0}, 1 + 1 + D);
        add(4, 64'h9001FF00_00000000, 0, 2, {8'h00, 8'h5A, 120'h0}, 1 + D);
        ntab = nv;
        for (int i = 0; i < ntab; i++) run_and_check(i);

        chk("cr_bw", CR_ADJ_BW, 8'h0A);
        chk("cr_lc", CR_ADJ_LC, 2);
        chk("cr_phy", CR_PHY_Instruct, 1);
        chk("eq_phy_in_cr", EQ_PHY_Instruct, 0);
        chk("eq_bw_in_cr", EQ_ADJ_BW, 0);

        add(5, 64'h80010200_02000000, 0, 1, {8'h00, 128'h0}, 1 + 1 + D);
        run_and_check(nv - 1);
        chk("eq_phy_during_commit", eq_hist[1], 0);
        chk("eq_phy_after_commit", eq_hist[2], 2);
        chk("eq_phy", EQ_PHY_Instruct, 2);
        chk("cr_phy_in_eq", CR_PHY_Instruct, 0);
        chk("eq_bw", EQ_ADJ_BW, 8'h0A);
        chk("eq_lc", EQ_ADJ_LC, 2);
        add(5, 64'h80010100_02000000, 0, 1, {8'h00, 128'h0}, 1 + 1 + D);
        run_and_check(nv - 1);
        chk("eq_lc_two_lanes", EQ_ADJ_LC, 1);

        hpd_connect = 1'b1;
        chk("hpd_not_yet", HPD_Signal, 0);
        @(posedge clk); #1;
        chk("hpd_connect", HPD_Signal, 1);
        repeat (2) @(posedge clk);
        #1 hpd_irq_req = 1'b1;
        low_n = 0; first_low = -1; last_low = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 1) hpd_irq_req = 1'b0;
            if (k == 5) hpd_irq_req = 1'b1;
            if (k == 6) hpd_irq_req = 1'b0;
            if (!HPD_Signal) begin
                low_n++;
                if (first_low < 0) first_low = k;
                last_low = k;
            end
        end
        chk("irq_first_low", first_low, 1);
        chk("irq_low_cycles", low_n, 16);
        chk("irq_last_low", last_low, 16);
        chk("irq_back_high", HPD_Signal, 1);

        hpd_irq_req = 1'b1;
        @(posedge clk); #1;
        hpd_irq_req = 1'b0;
        chk("irq2_low", HPD_Signal, 0);
        hpd_connect = 1'b0;
        @(posedge clk); #1;
        chk("abort_low", HPD_Signal, 0);
        hpd_connect = 1'b1;
        @(posedge clk); #1;
        chk("abort_reconnect", HPD_Signal, 1);

        hpd_irq_req = 1'b1;
        @(posedge clk); #1;
        hpd_irq_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_pulse_hpd", HPD_Signal, 0);
        chk("rst_eq_bw", EQ_ADJ_BW, 0);
        chk("rst_eq_phy", EQ_PHY_Instruct, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_hpd", HPD_Signal, 1);

        add(4, 64'h90010002_00000000, 0, 4, {8'h00, 8'h00, 8'h00, 8'h00, 104'h0}, 1 + D);
        run_and_check(nv - 1);
        add(4, 64'h90000002_00000000, 0, 4, {8'h00, 8'h14, 8'h1E, 8'h04, 104'h0}, 1 + D);
        run_and_check(nv - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_sink_aux_responder.md
# dp_sink_aux_responder

Parametrised DisplayPort sink-side AUX responder for the sink agent environment. It does four things:
- decodes native AUX request transactions framed by START_STOP;
- serves them from an internal DPCD byte array;
- returns ACK/NACK/DEFER replies;
- generates HPD level and IRQ pulses.

Training registers written by the source are mirrored onto the CR/EQ instruction outputs. Width, lane count, DPCD window and burst depth are parameters.

## Interface
- AUX_DATA_WIDTH, 8: AUX byte width.
- MAX_LANES, 4: lanes advertised in DPCD 0x002[4:0].
- MAX_LINK_RATE, 8'h1E: value of DPCD 0x001.
- DPCD_ADDR_WIDTH, 9: implemented window size, 2^N bytes from 0x00000.
- MAX_BURST, 16: maximum request length in bytes.
- REPLY_DELAY, 4: idle cycles between end of request (or end of commit) and the first reply byte.
- HPD_IRQ_CYCLES, 16: HPD low time for an IRQ pulse.

- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- aux_in  in  AUX_DATA_WIDTH  request byte from source
- aux_in_start_stop  in  1  high while the source drives request bytes
- aux_out  out  AUX_DATA_WIDTH  reply byte
- aux_out_start_stop  out  1  high while a reply byte is driven
- defer_req  in  1  forces DEFER on the request completing this cycle
- hpd_connect  in  1  connection level request
- hpd_irq_req  in  1  one-cycle pulse requesting an IRQ_HPD
- HPD_Signal  out  1  hot-plug detect
- CR_PHY_Instruct / EQ_PHY_Instruct  out  2  training pattern from DPCD 0x102[1:0]
  - CR_* is valid while 0x102[1:0]==1.
  - EQ_* is valid while 0x102[1:0] is 2 or 3.
  - Each is 0 otherwise.
- CR_ADJ_BW / EQ_ADJ_BW  out  AUX_DATA_WIDTH  mirror of DPCD 0x100
- CR_ADJ_LC / EQ_ADJ_LC  out  2  encoded lane count (1→0, 2→1, 4→2) from 0x101[4:0]; any other value → 0

## Operation
- Request format, one byte per cycle while aux_in_start_stop=1:
  - B0={cmd[3:0],addr[19:16]}; B1=addr[15:8]; B2=addr[7:0]; B3=len-1.
  - Write data bytes follow B3.
- Supported commands:
  - cmd 4'b1000: native write.
  - cmd 4'b1001: native read.
  - Any other cmd, including I2C: NACK.
- FSM states: IDLE → HDR (B0–B3) → DATA (writes only) → CHECK → COMMIT (writes only) → WAIT → REPLY → IDLE.
  - Side path: DRAIN, which waits for aux_in_start_stop to fall, then goes to IDLE.
- CHECK rules, in priority order:
  1. Malformed request: framing ends before B3, or a write's data count ≠ len. Discard with no reply and no writes.
  2. defer_req sampled on the falling-edge cycle: DEFER.
  3. Unsupported cmd, len > MAX_BURST, or addr+len > 2^DPCD_ADDR_WIDTH (window overrun, no wrap): NACK.
  4. Otherwise: ACK.
- Write data buffering: write data goes into a MAX_BURST-deep buffer. If more than MAX_BURST data bytes arrive, go to DRAIN and discard with no reply.
- COMMIT: writes one byte per cycle at addr+i.
  - Addresses 0x000–0x0FF are read-only. Writes there are skipped but still ACKed.
- Reply byte 0: {reply_cmd[3:0],4'b0}, with ACK=0000, NACK=0001, DEFER=0010.
  - ACK read: len data bytes follow, read from addr+i.
  - Write ACK, NACK and DEFER: byte 0 only.
- Requests arriving while not in IDLE are ignored.
- DPCD reset contents: 0x000=8'h14, 0x001=MAX_LINK_RATE, 0x002=MAX_LANES; all others 0.
- HPD:
  - HPD_Signal follows hpd_connect, registered.
  - hpd_irq_req while connected drives HPD_Signal low for exactly HPD_IRQ_CYCLES cycles, then high.
  - hpd_irq_req during an active pulse is ignored.
  - hpd_connect=0 aborts a pulse (HPD low).

## Timing
- Reset (rst_n=0 at a clk edge): FSM→IDLE, DPCD reloaded, all outputs 0. Reset mid-transaction discards the transaction.
- Request falling edge at cycle T: CHECK at T.
  - Read, or write NACK/DEFER: first reply byte with aux_out_start_stop=1 at T+1+REPLY_DELAY.
  - Write ACK: COMMIT occupies T+1..T+len; reply at T+1+len+REPLY_DELAY.
- Reply bytes are contiguous, one per cycle. aux_out_start_stop drops the cycle after the last byte, and aux_out returns to 0.
- Training outputs update the cycle after the COMMIT cycle that writes 0x100–0x102.
- HPD: registered one-cycle latency from hpd_connect or hpd_irq_req.

## Test plan
- Read capabilities: request {8'h90,8'h00,8'h00,8'h02} → reply 8'h00, 8'h14, 8'h1E, 8'h04, starting at fall+1+REPLY_DELAY.
- Write training: write 3 bytes to 0x100 with data 8'h0A, 8'h04, 8'h01 → ACK. Then CR_ADJ_BW=8'h0A, CR_ADJ_LC=2, CR_PHY_Instruct=1, EQ_*=0. A following write of 8'h02 to 0x102 → EQ_PHY_Instruct=2, CR_PHY_Instruct=0.
- Boundaries:
  - Read of len 17 → NACK.
  - Read at 0x1FF with len 2 → NACK.
  - Write of 1 byte to 0x001 → ACK, and 0x001 is unchanged.
  - Request with cmd 4'b0001 → NACK.
- defer_req=1 on the fall cycle of a write → single byte 8'h20, DPCD unchanged.
- Malformed: framing drops after B2 → no reply, FSM back in IDLE, and the next valid read is served normally.
- HPD: hpd_connect=1 → HPD_Signal=1 next cycle. hpd_irq_req pulse → HPD_Signal low for exactly 16 cycles. rst_n=0 during the pulse → HPD_Signal=0.
